// File: rtl/seg_display_mux.sv
`default_nettype none
// ============================================================================
// Module   : seg_display_mux
// Purpose  : Binary-to-BCD (double-dabble) converter feeding a time-multiplexed
//            seven-segment driver. Optional macro SEG_DISPLAY_LZB_EN enables
//            leading-zero blanking.
// Revision : 1.0 - initial release
// ============================================================================
module seg_display_mux #(
    parameter int NUM_DIGITS  = 4,
    parameter int VALUE_W     = 8,
    parameter int REFRESH_DIV = 50000
) (
    input  logic                  CLK,
    input  logic                  RESET_N,
    input  logic [VALUE_W-1:0]    VALUE,
    output logic [NUM_DIGITS-1:0] SEGA,
    output logic [7:0]            SEGD,
    output logic                  CONV_DONE
);

    localparam int BCD_W = NUM_DIGITS * 4;
    localparam int IDX_W = $clog2(NUM_DIGITS);
    localparam int CNT_W = $clog2(REFRESH_DIV);
    localparam int SC_W  = $clog2(VALUE_W) + 1;

    localparam logic [CNT_W-1:0] CNT_LAST   = CNT_W'(REFRESH_DIV - 1);
    localparam logic [IDX_W-1:0] IDX_LAST   = IDX_W'(NUM_DIGITS - 1);
    localparam logic [SC_W-1:0]  SC_LAST    = SC_W'(VALUE_W - 1);
    localparam logic [3:0]       CODE_DASH  = 4'hA;
    localparam logic [3:0]       CODE_BLANK = 4'hF;

    function automatic logic [31:0] max_display(input int n);
        logic [31:0] p;
        p = 32'd1;
        for (int k = 0; k < n; k++) begin
            p = p * 32'd10;
        end
        return p - 32'd1;
    endfunction

    localparam logic [31:0] MAX_VAL = max_display(NUM_DIGITS);

    // Active-low segment patterns, {dp,g,f,e,d,c,b,a}; dp always off.
    function automatic logic [7:0] seg_encode(input logic [3:0] code);
        case (code)
            4'd0:      return 8'hC0;
            4'd1:      return 8'hF9;
            4'd2:      return 8'hA4;
            4'd3:      return 8'hB0;
            4'd4:      return 8'h99;
            4'd5:      return 8'h92;
            4'd6:      return 8'h82;
            4'd7:      return 8'hF8;
            4'd8:      return 8'h80;
            4'd9:      return 8'h90;
            CODE_DASH: return 8'hBF;
            default:   return 8'hFF;
        endcase
    endfunction

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOAD  = 2'd1,
        ST_SHIFT = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    state_t             r_state;
    logic [VALUE_W-1:0] r_bin;
    logic [BCD_W-1:0]   r_bcd;
    logic [BCD_W-1:0]   w_bcd_adj;
    logic [SC_W-1:0]    r_sc;
    logic               r_ovf;
    logic [BCD_W-1:0]   r_digits;

    always_comb begin
        w_bcd_adj = r_bcd;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (r_bcd[i*4 +: 4] >= 4'd5) begin
                w_bcd_adj[i*4 +: 4] = r_bcd[i*4 +: 4] + 4'd3;
            end
        end
    end

    // Overflow is decided at capture time so the shift engine never needs the
    // original value again.
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            r_state   <= ST_IDLE;
            r_bin     <= '0;
            r_bcd     <= '0;
            r_sc      <= '0;
            r_ovf     <= 1'b0;
            r_digits  <= '0;
            CONV_DONE <= 1'b0;
        end else begin
            CONV_DONE <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    r_state <= ST_LOAD;
                end
                ST_LOAD: begin
                    r_bin   <= VALUE;
                    r_bcd   <= '0;
                    r_sc    <= '0;
                    r_ovf   <= (32'(VALUE) > MAX_VAL);
                    r_state <= ST_SHIFT;
                end
                ST_SHIFT: begin
                    r_bcd <= BCD_W'({w_bcd_adj, r_bin[VALUE_W-1]});
                    r_bin <= r_bin << 1;
                    r_sc  <= r_sc + SC_W'(1);
                    if (r_sc == SC_LAST) begin
                        r_state <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    r_digits  <= r_ovf ? {NUM_DIGITS{CODE_DASH}} : r_bcd;
                    CONV_DONE <= 1'b1;
                    r_state   <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

`ifdef SEG_DISPLAY_LZB_EN
    logic [NUM_DIGITS-1:0] w_blank;
    logic                  w_upper_zero;

    // A digit blanks only when it and every digit above it are zero.
    always_comb begin
        w_blank      = '0;
        w_upper_zero = 1'b1;
        for (int i = NUM_DIGITS - 1; i > 0; i--) begin
            w_upper_zero = w_upper_zero & (r_digits[i*4 +: 4] == 4'd0);
            w_blank[i]   = w_upper_zero;
        end
    end
`endif

    logic [CNT_W-1:0] r_cnt;
    logic [IDX_W-1:0] r_idx;
    logic [3:0]       w_code;

    always_comb begin
        w_code = 4'd0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (r_idx == IDX_W'(i)) begin
                w_code = r_digits[i*4 +: 4];
`ifdef SEG_DISPLAY_LZB_EN
                if (w_blank[i]) begin
                    w_code = CODE_BLANK;
                end
`endif
            end
        end
    end

    // Anode and segment lines load together from the same index.
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            r_cnt <= '0;
            r_idx <= '0;
            SEGA  <= '1;
            SEGD  <= 8'hFF;
        end else begin
            SEGA <= ~(NUM_DIGITS'(1) << r_idx);
            SEGD <= seg_encode(w_code);
            if (r_cnt == CNT_LAST) begin
                r_cnt <= '0;
                r_idx <= (r_idx == IDX_LAST) ? '0 : r_idx + IDX_W'(1);
            end else begin
                r_cnt <= r_cnt + CNT_W'(1);
            end
        end
    end

endmodule
`default_nettype wire
